instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_seq_pkg.sv | 38 +++
 rtl/instr_decode.sv | 28 ++
 rtl/instr_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, instruction
// field positions, special encodings and the ALU op codes seen by the regfile/ALU.
package instr_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  localparam logic [2:0]  OP_BZ     = 3'b111;

  localparam int unsigned I_BIT  = 15;
  localparam int unsigned OP_HI  = 14;
  localparam int unsigned OP_LO  = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 8;
  localparam int unsigned RS_HI  = 3;
  localparam int unsigned RS_LO  = 0;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: splits a 16-bit word into control fields
// and flags the HALT and branch-if-zero encodings.
module instr_decode
  import instr_seq_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [3:0]  rdest_o,
  output logic [3:0]  rsrc_o,
  output logic [3:0]  opcode_o,
  output logic [15:0] imm_o,
  output logic        imm_s_o,
  output logic        is_halt_o,
  output logic        is_bz_o
);

  logic imm_mode;

  assign imm_mode  = word_i[I_BIT];
  assign rdest_o   = word_i[RD_HI:RD_LO];
  // In immediate form the low nibble belongs to imm8, so no source register.
  assign rsrc_o    = imm_mode ? 4'd0 : word_i[RS_HI:RS_LO];
  assign opcode_o  = {1'b0, word_i[OP_HI:OP_LO]};
  assign imm_o     = imm_mode ? sext8(word_i[IMM_HI:IMM_LO]) : 16'd0;
  assign imm_s_o   = imm_mode;
  assign is_halt_o = (word_i == HALT_WORD);
  assign is_bz_o   = imm_mode && (word_i[OP_HI:OP_LO] == OP_BZ) && !is_halt_o;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer driving the regfile/ALU from a 16-bit
// instruction memory, with branch-if-zero and a terminal HALT.
//   state  | meaning
//   IDLE   | waiting for Start after reset
//   FETCH  | ImemReq high at PC until ImemAck
//   DECODE | register control fields from the latched word
//   EXEC   | En pulse for ALU ops, PC update
//   HALT   | stopped until reset
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ZBIT   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic [15:0]       ImemData,
  input  logic [4:0]        Flags,
  output logic [3:0]        RdestRegLoc,
  output logic [3:0]        RsrcRegLoc,
  output logic [3:0]        OpCode,
  output logic [15:0]       Imm,
  output logic              Imm_s,
  output logic              En,
  output logic              Halted
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [3:0]        rdest_q, rdest_d, rsrc_q, rsrc_d, opcode_q, opcode_d;
  logic [15:0]       imm_q, imm_d;
  logic              imm_s_q, imm_s_d, bz_q, bz_d;

  logic [3:0]        dec_rdest, dec_rsrc, dec_opcode;
  logic [15:0]       dec_imm;
  logic              dec_imm_s, dec_halt, dec_bz;
  logic [ADDR_W-1:0] br_off;
  logic              flags_unused;

  instr_decode u_decode (
    .word_i    (instr_q),
    .rdest_o   (dec_rdest),
    .rsrc_o    (dec_rsrc),
    .opcode_o  (dec_opcode),
    .imm_o     (dec_imm),
    .imm_s_o   (dec_imm_s),
    .is_halt_o (dec_halt),
    .is_bz_o   (dec_bz)
  );

  // Branch offset is imm8 sign-extended (or truncated) to the PC width.
  assign br_off       = ADDR_W'($signed(instr_q[7:0]));
  assign flags_unused = ^Flags;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rdest_d  = rdest_q;
    rsrc_d   = rsrc_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    imm_s_d  = imm_s_q;
    bz_d     = bz_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (ImemAck) begin
          instr_d = ImemData;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          rdest_d  = dec_rdest;
          rsrc_d   = dec_rsrc;
          opcode_d = dec_opcode;
          imm_d    = dec_imm;
          imm_s_d  = dec_imm_s;
          bz_d     = dec_bz;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d    = (bz_q && Flags[ZBIT]) ? pc_q + br_off : pc_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      opcode_q <= '0;
      imm_q    <= '0;
      imm_s_q  <= 1'b0;
      bz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rdest_q  <= rdest_d;
      rsrc_q   <= rsrc_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      imm_s_q  <= imm_s_d;
      bz_q     <= bz_d;
    end
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  assign ImemReq     = (state_q == ST_FETCH);
  assign ImemAddr    = pc_q;
  assign En          = (state_q == ST_EXEC) && !bz_q;
  assign Halted      = (state_q == ST_HALT);
  assign RdestRegLoc = rdest_q;
  assign RsrcRegLoc  = rsrc_q;
  assign OpCode      = opcode_q;
  assign Imm         = imm_q;
  assign Imm_s       = imm_s_q;

endmodule
